// File: rtl/phase_peak_scheduler.sv
// -----------------------------------------------------------------------------
// phase_peak_scheduler
//
// Runs the phase detector once per FFT frame. The FFT output stream is snooped
// and the peak-magnitude bin of the lower half-spectrum is tracked. Once the
// frame's last beat has been seen, the peak bin is handed to the phase detector
// as a one-cycle request (k_max/k_max_valid). The returned phase pair is then
// captured, and one result beat per frame is emitted over valid/ready.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   fft_tdata[47:0]       {im[47:24], re[23:0]}, signed two's complement
//   fft_tvalid/tlast      snooped FFT beat qualifiers (no backpressure)
//   fft_tuser[15:0]       bin index in [ADDR_WIDTH-1:0]
//   k_max, k_max_valid    peak bin request to the phase detector (held value,
//                         one-cycle pulse)
//   phase, phase_last,    phase detector response
//   phases_valid
//   out_tvalid/out_tready result handshake
//   out_bin, out_phase,   result fields (out_dphase = phase - phase_last,
//   out_dphase,           wrapping modulo 2**PHASE_WIDTH)
//   out_timeout
//   drop_count[7:0]       saturating count of dropped frames
//
// Build option
//   PEAK_THRESHOLD_EN     adds mag_threshold[24:0] input and out_silent output.
//                         Frames whose peak magnitude is below the threshold
//                         skip the phase detector and produce a silent result.
//
// State table
//   state      | meaning
//   S_COLLECT  | searching the current frame for its peak
//   S_ISSUE    | k_max_valid high for one cycle
//   S_WAIT_PH  | waiting for phases_valid or the timeout
//   S_OUTPUT   | result beat presented, waiting for out_tready
// -----------------------------------------------------------------------------
module phase_peak_scheduler #(
  parameter int ADDR_WIDTH     = 11,
  parameter int PHASE_WIDTH    = 24,
  parameter bit SKIP_DC        = 1'b1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [47:0]            fft_tdata,
  input  logic                   fft_tvalid,
  input  logic                   fft_tlast,
  input  logic [15:0]            fft_tuser,
  output logic [ADDR_WIDTH-1:0]  k_max,
  output logic                   k_max_valid,
  input  logic [PHASE_WIDTH-1:0] phase,
  input  logic [PHASE_WIDTH-1:0] phase_last,
  input  logic                   phases_valid,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [ADDR_WIDTH-1:0]  out_bin,
  output logic [PHASE_WIDTH-1:0] out_phase,
  output logic [PHASE_WIDTH-1:0] out_dphase,
  output logic                   out_timeout,
`ifdef PEAK_THRESHOLD_EN
  input  logic [24:0]            mag_threshold,
  output logic                   out_silent,
`endif
  output logic [7:0]             drop_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] DC_BIN = SKIP_DC ? ADDR_WIDTH'(1) : '0;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_PH = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;

  // magnitude pipe stage
  logic [24:0]            mag_q, mag_d;
  logic [ADDR_WIDTH-1:0]  bin_q, bin_d;
  logic                   cand_q, cand_d;
  logic                   last_q, last_d;
  logic                   acc_last_q, acc_last_d;

  // running peak
  logic [24:0]            max_q, max_d;
  logic [ADDR_WIDTH-1:0]  max_bin_q, max_bin_d;

  logic                   drop_pending_q, drop_pending_d;
  logic [7:0]             drop_count_q, drop_count_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0]  k_max_q, k_max_d;
  logic                   k_max_valid_q, k_max_valid_d;
  logic                   out_tvalid_q, out_tvalid_d;
  logic [ADDR_WIDTH-1:0]  out_bin_q, out_bin_d;
  logic [PHASE_WIDTH-1:0] out_phase_q, out_phase_d;
  logic [PHASE_WIDTH-1:0] out_dphase_q, out_dphase_d;
  logic                   out_timeout_q, out_timeout_d;
`ifdef PEAK_THRESHOLD_EN
  logic                   out_silent_q, out_silent_d;
`endif

  logic [24:0]            re_ext, im_ext, abs_re, abs_im;
  logic [ADDR_WIDTH-1:0]  beat_bin;
  logic                   in_collect, accept;
  logic                   upd;
  logic [24:0]            peak_mag;
  logic [ADDR_WIDTH-1:0]  peak_bin;

  // Only the low ADDR_WIDTH bits of tuser carry the bin index.
  logic                   unused_tuser;
  assign unused_tuser = ^fft_tuser[15:ADDR_WIDTH];

  always_comb begin
    // |x| on a 25-bit extension so that -2**23 maps to +2**23 without clipping
    re_ext   = {fft_tdata[23], fft_tdata[23:0]};
    im_ext   = {fft_tdata[47], fft_tdata[47:24]};
    abs_re   = fft_tdata[23] ? (25'd0 - re_ext) : re_ext;
    abs_im   = fft_tdata[47] ? (25'd0 - im_ext) : im_ext;
    beat_bin = fft_tuser[ADDR_WIDTH-1:0];

    in_collect = (state_q == S_COLLECT);
    accept     = fft_tvalid && in_collect && !drop_pending_q;

    mag_d      = abs_re + abs_im;
    bin_d      = beat_bin;
    cand_d     = accept && !beat_bin[ADDR_WIDTH-1] &&
                 (!SKIP_DC || (beat_bin != '0));
    last_d     = fft_tvalid && fft_tlast;
    acc_last_d = accept && fft_tlast;

    // Strict compare: on a tie the earlier (lower) bin is kept.
    upd      = cand_q && (mag_q > max_q);
    peak_mag = upd ? mag_q : max_q;
    peak_bin = upd ? bin_q : max_bin_q;

    // Any frame end re-arms the search, including ends of dropped frames.
    max_d     = last_q ? 25'd0 : peak_mag;
    max_bin_d = last_q ? DC_BIN : peak_bin;

    // A beat arriving outside COLLECT poisons the rest of its frame; the
    // frame is counted as dropped at its tlast.
    drop_pending_d = drop_pending_q;
    drop_count_d   = drop_count_q;
    if (fft_tvalid && (drop_pending_q || !in_collect)) begin
      if (fft_tlast) begin
        drop_pending_d = 1'b0;
        if (drop_count_q != 8'hFF) begin
          drop_count_d = drop_count_q + 8'd1;
        end
      end else begin
        drop_pending_d = 1'b1;
      end
    end

    state_d       = state_q;
    cnt_d         = cnt_q;
    k_max_d       = k_max_q;
    k_max_valid_d = 1'b0;
    out_tvalid_d  = out_tvalid_q;
    out_bin_d     = out_bin_q;
    out_phase_d   = out_phase_q;
    out_dphase_d  = out_dphase_q;
    out_timeout_d = out_timeout_q;
`ifdef PEAK_THRESHOLD_EN
    out_silent_d  = out_silent_q;
`endif

    case (state_q)
      S_COLLECT: begin
        if (acc_last_q) begin
`ifdef PEAK_THRESHOLD_EN
          if (peak_mag < mag_threshold) begin
            state_d       = S_OUTPUT;
            out_tvalid_d  = 1'b1;
            out_bin_d     = '0;
            out_phase_d   = '0;
            out_dphase_d  = '0;
            out_timeout_d = 1'b0;
            out_silent_d  = 1'b1;
          end else begin
            state_d       = S_ISSUE;
            k_max_d       = peak_bin;
            k_max_valid_d = 1'b1;
          end
`else
          state_d       = S_ISSUE;
          k_max_d       = peak_bin;
          k_max_valid_d = 1'b1;
`endif
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT_PH;
        cnt_d   = CNT_W'(TIMEOUT_CYCLES);
      end

      S_WAIT_PH: begin
        // phases_valid is checked first so it wins a same-cycle timeout.
        if (phases_valid) begin
          state_d       = S_OUTPUT;
          out_tvalid_d  = 1'b1;
          out_bin_d     = k_max_q;
          out_phase_d   = phase;
          out_dphase_d  = phase - phase_last;
          out_timeout_d = 1'b0;
`ifdef PEAK_THRESHOLD_EN
          out_silent_d  = 1'b0;
`endif
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d       = S_OUTPUT;
          out_tvalid_d  = 1'b1;
          out_bin_d     = k_max_q;
          out_phase_d   = '0;
          out_dphase_d  = '0;
          out_timeout_d = 1'b1;
`ifdef PEAK_THRESHOLD_EN
          out_silent_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_OUTPUT: begin
        if (out_tready) begin
          state_d      = S_COLLECT;
          out_tvalid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_COLLECT;
      mag_q          <= '0;
      bin_q          <= '0;
      cand_q         <= 1'b0;
      last_q         <= 1'b0;
      acc_last_q     <= 1'b0;
      max_q          <= '0;
      max_bin_q      <= DC_BIN;
      drop_pending_q <= 1'b0;
      drop_count_q   <= '0;
      cnt_q          <= '0;
      k_max_q        <= '0;
      k_max_valid_q  <= 1'b0;
      out_tvalid_q   <= 1'b0;
      out_bin_q      <= '0;
      out_phase_q    <= '0;
      out_dphase_q   <= '0;
      out_timeout_q  <= 1'b0;
`ifdef PEAK_THRESHOLD_EN
      out_silent_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      mag_q          <= mag_d;
      bin_q          <= bin_d;
      cand_q         <= cand_d;
      last_q         <= last_d;
      acc_last_q     <= acc_last_d;
      max_q          <= max_d;
      max_bin_q      <= max_bin_d;
      drop_pending_q <= drop_pending_d;
      drop_count_q   <= drop_count_d;
      cnt_q          <= cnt_d;
      k_max_q        <= k_max_d;
      k_max_valid_q  <= k_max_valid_d;
      out_tvalid_q   <= out_tvalid_d;
      out_bin_q      <= out_bin_d;
      out_phase_q    <= out_phase_d;
      out_dphase_q   <= out_dphase_d;
      out_timeout_q  <= out_timeout_d;
`ifdef PEAK_THRESHOLD_EN
      out_silent_q   <= out_silent_d;
`endif
    end
  end

  assign k_max       = k_max_q;
  assign k_max_valid = k_max_valid_q;
  assign out_tvalid  = out_tvalid_q;
  assign out_bin     = out_bin_q;
  assign out_phase   = out_phase_q;
  assign out_dphase  = out_dphase_q;
  assign out_timeout = out_timeout_q;
  assign drop_count  = drop_count_q;
`ifdef PEAK_THRESHOLD_EN
  assign out_silent  = out_silent_q;
`endif

endmodule

// File: doc/phase_peak_scheduler.md
Name: phase_peak_scheduler

Overview:
- Sequences the phase detector once per FFT frame.
- Snoops the FFT output stream and finds the peak-magnitude bin in the lower half-spectrum. After the frame's last beat it issues k_max/k_max_valid to the phase detector, then captures phase and phase_last.
- Emits one result beat per frame (bin, phase, wrapped phase delta) over a valid/ready handshake to the downstream pitch-shift stage.

Parameters:
- ADDR_WIDTH, 11, FFT size is 2**ADDR_WIDTH; peak search covers bins 0..2**(ADDR_WIDTH-1)-1.
- PHASE_WIDTH, 24, phase word width.
- SKIP_DC, 1, when 1, bin 0 is excluded from the peak search.
- TIMEOUT_CYCLES, 15, maximum cycles in WAIT_PH before abort.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fft_tdata  in  48  {im[47:24], re[23:0]}, signed two's complement.
- fft_tvalid  in  1  FFT beat valid (snooped, no backpressure).
- fft_tlast  in  1  last beat of frame.
- fft_tuser  in  16  bin index in [ADDR_WIDTH-1:0].
- k_max  out  ADDR_WIDTH  peak bin to phase detector.
- k_max_valid  out  1  one-cycle request pulse.
- phase  in  PHASE_WIDTH  current-window phase.
- phase_last  in  PHASE_WIDTH  previous-window phase.
- phases_valid  in  1  phase/phase_last valid.
- out_tvalid  out  1  result valid.
- out_tready  in  1  downstream ready.
- out_bin  out  ADDR_WIDTH  peak bin of the frame.
- out_phase  out  PHASE_WIDTH  captured phase.
- out_dphase  out  PHASE_WIDTH  phase - phase_last, modulo 2**PHASE_WIDTH.
- out_timeout  out  1  result aborted by timeout (phase fields zero).
- drop_count  out  8  saturating count of dropped frames.

Behaviour:
- Reset values: all outputs 0; state IDLE_COLLECT; running max 0; drop_pending 0.
- Magnitude:
  - mag = |re| + |im|, 25 bits unsigned. |x| of -2**23 is 2**23 (no saturation).
  - mag is registered with the bin index and the last flag: a 1-cycle pipe.
- Search:
  - Active only in state COLLECT with drop_pending=0.
  - Candidate beats have tvalid=1 and tuser[ADDR_WIDTH-1]=0. Bin 0 is excluded when SKIP_DC=1.
  - Update the running max only when mag > max (strictly). Ties therefore keep the lowest bin.
  - After each frame's tlast the max resets to 0 and the bin resets to SKIP_DC.
- States:
  - COLLECT: on the registered last flag -> ISSUE.
  - ISSUE: drive k_max = peak bin with k_max_valid=1 for exactly one cycle -> WAIT_PH.
  - WAIT_PH:
    - On phases_valid, capture phase, compute out_dphase and set out_timeout=0 -> OUTPUT.
    - If the cycle counter reaches TIMEOUT_CYCLES first, set out_timeout=1 and out_phase/out_dphase=0 -> OUTPUT.
    - If phases_valid arrives in the same cycle as the timeout, phases_valid wins.
  - OUTPUT: out_tvalid=1. All out_* fields stay stable until out_tvalid & out_tready -> COLLECT. out_tvalid drops the cycle after the handshake.
- Latency: tlast beat at cycle T -> k_max_valid at T+2 -> phases_valid nominally at T+4 -> out_tvalid at T+5.
- k_max holds its value after ISSUE until the next ISSUE, as the phase detector reads it while it is idle.
- Frame drop:
  - Any fft_tvalid beat seen while state != COLLECT sets drop_pending.
  - While drop_pending=1, beats are ignored until that frame's tlast. That tlast clears drop_pending and increments drop_count, saturating at 255.
  - If the state returns to COLLECT mid-frame, the remainder of that frame is still ignored.
- out_dphase: two's-complement subtraction truncated to PHASE_WIDTH. This gives a natural wrap at ±pi.
- Reset mid-operation: returns to COLLECT, clears the max and drop_count, and deasserts out_tvalid and k_max_valid on the next edge. Any in-flight frame is discarded silently.

Optional Feature:
- Macro: PEAK_THRESHOLD_EN.
- When defined:
  - Adds input mag_threshold [24:0].
  - In COLLECT, on the last flag with peak mag < mag_threshold, skip ISSUE/WAIT_PH and go straight to OUTPUT.
  - The beat carries out_bin=0, phase fields 0, and new output out_silent=1.
  - out_silent=0 on normal results.
- When undefined: no mag_threshold or out_silent ports; every frame is issued.

Test Plan:
- Single-peak frame, ADDR_WIDTH=4:
  - Stimulus: bin 5 re=1000, im=-200; other bins mag ≤ 50; phases_valid 2 cycles after the request with phase=0x100000, phase_last=0x0F0000.
  - Required: k_max=5 pulse at T+2; out_bin=5, out_phase=0x100000, out_dphase=0x010000, out_timeout=0.
- Tie and DC:
  - Stimulus: bins 0, 3 and 6 each with mag 500, SKIP_DC=1.
  - Required: out_bin=3.
  - With SKIP_DC=0: out_bin=0.
- Wrap:
  - Stimulus: phase=0x800010, phase_last=0x7FFFF0.
  - Required: out_dphase=0x000020.
  - Stimulus: phase=0x000000, phase_last=0xFFFFFF.
  - Required: out_dphase=0x000001.
- Timeout: phases_valid never asserted -> out_tvalid 15 cycles after WAIT_PH entry with out_timeout=1.
- Backpressure and drop:
  - Stimulus: hold out_tready=0 while the next frame streams.
  - Required: that frame is dropped, drop_count=1, outputs stay stable.
  - Release out_tready mid-frame -> the rest of that frame is still ignored; the following frame is processed normally.
- Reset mid-WAIT_PH: reset asserted for 1 cycle -> no out_tvalid, drop_count=0, the next frame produces a correct result.
